// File: rtl/i2c_txn_scheduler.sv
// Round-robin arbiter that shares one I2C node's controller request port among NUM_REQ requesters.
// It issues one transaction at a time, waits for done or a timeout, and can hold the grant for repeated-start chains.
module i2c_txn_scheduler #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ-1:0]             req_restart,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_error,
  output logic [DATA_WIDTH-1:0]          controller_data_req,
  output logic [ADDR_WIDTH-1:0]          controller_addr_req,
  output logic                           controller_valid_req,
  output logic                           controller_operation_req,
  output logic                           controller_restart_req,
  output logic                           error_signal,
  input  logic [DATA_WIDTH-1:0]          controller_data_rsp,
  input  logic                           controller_done
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ID_W-1:0]       r_rr_ptr;
  logic                  r_lock;
  logic [ID_W-1:0]       r_lock_id;
  logic [CNT_W-1:0]      r_cnt;
  logic [ID_W-1:0]       r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_op;
  logic                  r_restart;
  logic                  r_cvalid;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_error;

  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_cand;
  logic                  w_timeout;
  logic                  w_accept;

  // Winner search: a locked grant overrides round-robin; otherwise scan upward from rr_ptr
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    if (r_lock) begin
      w_found  = req_valid[r_lock_id];
      w_winner = r_lock_id;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_found && req_valid[w_cand]) begin
          w_found  = 1'b1;
          w_winner = w_cand;
        end
      end
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_found;
  assign req_ready = w_accept ? ((NUM_REQ'(1) << w_winner) & {NUM_REQ{rst_n}}) : '0;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_found) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (controller_done) begin
          w_next = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Capture, counter, response and lock bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_lock_id   <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_op        <= 1'b0;
      r_restart   <= 1'b0;
      r_cvalid    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_cvalid    <= (w_next == ST_ISSUE);
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_id      <= w_winner;
        r_addr    <= req_addr[32'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
        r_data    <= req_data[32'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
        r_op      <= req_op[w_winner];
        r_restart <= req_restart[w_winner];
        r_rr_ptr  <= (w_winner == ID_LAST) ? '0 : w_winner + ID_W'(1);
      end
      if (r_state == ST_ISSUE)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == ST_WAIT && w_next == ST_RESP) begin
        r_rsp_valid <= NUM_REQ'(1) << r_id;
        r_rsp_data  <= (controller_done && r_op) ? controller_data_rsp : '0;
        r_rsp_error <= w_timeout;
      end
      // A timed-out transaction never keeps the bus, even if it asked for a restart
      if (r_state == ST_RESP) begin
        r_lock    <= r_restart & ~r_rsp_error;
        r_lock_id <= r_id;
      end
    end
  end

  assign controller_data_req      = r_data;
  assign controller_addr_req      = r_addr;
  assign controller_valid_req     = r_cvalid;
  assign controller_operation_req = r_op;
  assign controller_restart_req   = r_restart;
  assign error_signal             = w_timeout;
  assign rsp_valid                = r_rsp_valid;
  assign rsp_data                 = r_rsp_data;
  assign rsp_error                = r_rsp_error;

endmodule
